// File: rtl/pulse_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_request_arbiter_if
// Brief    : Request/grant bundle between pulsers, arbiter and the consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0] req_in;
    logic               consumer_ready;
    logic               clear_overflow;
    logic               pulse_out;
    logic [IDW-1:0]     pulse_id;
    logic [NUM_REQ-1:0] pending_out;
    logic [NUM_REQ-1:0] overflow_out;
    logic               busy_out;

    modport master (
        output req_in, consumer_ready, clear_overflow,
        input  pulse_out, pulse_id, pending_out, overflow_out, busy_out
    );

    modport slave (
        input  req_in, consumer_ready, clear_overflow,
        output pulse_out, pulse_id, pending_out, overflow_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/pulse_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_request_arbiter
// Brief    : Edge-detected pending requests granted round-robin onto one
//            single-cycle pulse, with consumer handshake and guard gap.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int MIN_GAP = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    pulse_request_arbiter_if.slave  bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    localparam int              c_GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_LOAD = (MIN_GAP > 0) ? c_GW'(MIN_GAP - 1) : '0;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [NUM_REQ-1:0] r_prev_req;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_overflow;
    logic [NUM_REQ-1:0] w_edge;
    logic [NUM_REQ-1:0] w_win_mask;
    logic [NUM_REQ-1:0] w_grant_mask;
    logic [NUM_REQ-1:0] w_ovf_set;
    logic [IDW-1:0]     r_rr_last;
    logic [IDW-1:0]     r_pulse_id;
    logic [IDW-1:0]     w_winner;
    logic [c_GW-1:0]    r_gap_cnt;
    logic               w_can_issue;
    logic               w_grant;

    // The last gap cycle may hand straight over to the next grant so the issue
    // period stays at 1+MIN_GAP; with no gap, back-to-back grants are allowed.
    assign w_can_issue = (r_state == c_IDLE)
                      || ((r_state == c_GAP) && (r_gap_cnt == '0))
                      || ((r_state == c_ISSUE) && (MIN_GAP == 0));
    assign w_grant     = w_can_issue && bus.consumer_ready && (|r_pending);

    assign w_edge       = bus.req_in & ~r_prev_req;
    assign w_grant_mask = w_grant ? w_win_mask : '0;
    assign w_ovf_set    = w_edge & r_pending & ~w_grant_mask;

    // Round-robin search: first pending index after r_rr_last, wrapping.
    always_comb begin
        int   v_idx;
        logic v_found;
        v_idx      = 0;
        v_found    = 1'b0;
        w_winner   = '0;
        w_win_mask = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = (int'(r_rr_last) + k) % NUM_REQ;
            if (!v_found && r_pending[v_idx]) begin
                v_found           = 1'b1;
                w_winner          = IDW'(v_idx);
                w_win_mask[v_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_grant) w_next_state = c_ISSUE;
            c_ISSUE: begin
                if (w_grant)          w_next_state = c_ISSUE;
                else if (MIN_GAP > 0) w_next_state = c_GAP;
                else                  w_next_state = c_IDLE;
            end
            c_GAP: begin
                if (w_grant)                w_next_state = c_ISSUE;
                else if (r_gap_cnt == '0)   w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.pulse_out    = (r_state == c_ISSUE);
        bus.pulse_id     = (r_state == c_ISSUE) ? r_pulse_id : '0;
        bus.busy_out     = (r_state == c_ISSUE) || (r_state == c_GAP);
        bus.pending_out  = r_pending;
        bus.overflow_out = r_overflow;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_req <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
            r_gap_cnt  <= '0;
            r_pulse_id <= '0;
            r_rr_last  <= IDW'(NUM_REQ - 1);
        end else begin
            r_prev_req <= bus.req_in;
            // A fresh edge on the channel being granted re-arms it.
            r_pending  <= (r_pending & ~w_grant_mask) | w_edge;
            r_overflow <= (bus.clear_overflow ? '0 : r_overflow) | w_ovf_set;
            if (w_grant) begin
                r_pulse_id <= w_winner;
                r_rr_last  <= w_winner;
            end
            if (r_state == c_ISSUE) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if ((r_state == c_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
